// File: rtl/ser_pkg.sv
// Shared definitions for the frame serializer and its deserializer peer.
// - ser_state_t        : serializer FSM states
// - DefaultSyncW/Pattern: sync word both ends must agree on
// - ParBits            : 1 when FRAME_SERIALIZER_PARITY_EN is defined, else 0
// - frame_cycles()     : clk cycles spanned by one frame (sync + data + parity)
package ser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StPar,
    StGap
  } ser_state_t;

  localparam int unsigned DefaultSyncW = 8;
  localparam logic [DefaultSyncW-1:0] DefaultSyncPattern = 8'hA5;

`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

  function automatic int unsigned frame_cycles(input int unsigned sync_w,
                                               input int unsigned data_w,
                                               input int unsigned bit_div);
    return (sync_w + data_w + ParBits) * bit_div;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Serial bit timer: counts 0..BIT_DIV-1 while enabled, held at 0 while cleared.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   clr_i          : force count to 0 (takes priority over en_i)
//   en_i           : advance the count
//   bit_start_o    : count is 0 (first cycle of a bit)
//   bit_end_o      : count is BIT_DIV-1 (last cycle of a bit)
module ser_bit_timer #(
  parameter int unsigned BIT_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_start_o,
  output logic bit_end_o
);

  localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CntW-1:0] count_q, count_d;
  logic            last;

  assign last        = (count_q == CntW'(BIT_DIV - 1));
  assign bit_start_o = (count_q == '0);
  assign bit_end_o   = last;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: takes parallel words over valid/ready and sends each as a
// serial frame: SYNC_PATTERN (MSB first), data word (MSB first), optional even
// parity bit, then GAP_BITS idle bits at line level 0.
// Optional feature macro: FRAME_SERIALIZER_PARITY_EN (adds the parity bit).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   en           : allows new frames to start; running frames always finish
//   s_data/s_valid/s_ready : input word handshake into a one-word holding register
//   ser_dout     : registered serial data
//   ser_frame    : high for every sync/data/parity bit
//   ser_bit_stb  : pulse on the first cycle of each frame bit
//   busy         : FSM active or holding register full
//   frame_cnt    : completed frames, wrapping
module frame_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SYNC_W = DefaultSyncW,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = DefaultSyncPattern,
  parameter int unsigned BIT_DIV = 4,
  parameter int unsigned GAP_BITS = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_dout,
  output logic              ser_frame,
  output logic              ser_bit_stb,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned ShW     = SYNC_W + DATA_W;
  localparam int unsigned MaxSD   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MaxBits = (MaxSD > GAP_BITS) ? MaxSD : GAP_BITS;
  localparam int unsigned IdxW    = $clog2(MaxBits + 1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              s_ready_q, s_ready_d;
  logic [ShW-1:0]    sh_q, sh_d;
  logic              dout_q, dout_d;
  logic              frame_q, frame_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic           bit_start, bit_end;
  logic           accept, load, end_frame, go_next;
  logic [ShW-1:0] frame_bits;

  ser_bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_bit_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (state_q == StIdle),
    .en_i       (1'b1),
    .bit_start_o(bit_start),
    .bit_end_o  (bit_end)
  );

  assign frame_bits = {SYNC_PATTERN, hold_q};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    dout_d      = dout_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
`ifdef FRAME_SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    // s_ready_q high implies the holding register is empty, so accept and
    // load (which needs it full) are mutually exclusive.
    accept      = s_valid & s_ready_q;
    load        = 1'b0;
    end_frame   = 1'b0;
    go_next     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q && en) load = 1'b1;
      end
      StSync: begin
        if (bit_end) begin
          dout_d = sh_q[ShW-1];
          sh_d   = sh_q << 1;
          if (idx_q == IdxW'(SYNC_W - 1)) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxW'(DATA_W - 1)) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
            state_d = StPar;
            dout_d  = par_q;
`else
            end_frame = 1'b1;
`endif
          end else begin
            dout_d = sh_q[ShW-1];
            sh_d   = sh_q << 1;
            idx_d  = idx_q + IdxW'(1);
          end
        end
      end
`ifdef FRAME_SERIALIZER_PARITY_EN
      StPar: begin
        if (bit_end) end_frame = 1'b1;
      end
`endif
      StGap: begin
        if (bit_end) begin
          if (idx_q == IdxW'(GAP_BITS - 1)) go_next = 1'b1;
          else idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (end_frame) begin
      cnt_d   = cnt_q + CNT_W'(1);
      dout_d  = 1'b0;
      frame_d = 1'b0;
      idx_d   = '0;
      if (GAP_BITS > 0) state_d = StGap;
      else go_next = 1'b1;
    end

    if (go_next) begin
      if (hold_full_q && en) load = 1'b1;
      else state_d = StIdle;
    end

    // Load drives sync bit 0 on the same edge; the rest shifts out of sh_q.
    if (load) begin
      state_d = StSync;
      dout_d  = frame_bits[ShW-1];
      sh_d    = frame_bits << 1;
      frame_d = 1'b1;
      idx_d   = '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_d   = ^hold_q;
`endif
    end

    if (accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
    s_ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      s_ready_q   <= 1'b0;
      sh_q        <= '0;
      dout_q      <= 1'b0;
      frame_q     <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      s_ready_q   <= s_ready_d;
      sh_q        <= sh_d;
      dout_q      <= dout_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign s_ready     = s_ready_q;
  assign ser_dout    = dout_q;
  assign ser_frame   = frame_q;
  assign ser_bit_stb = bit_start & frame_q;
  assign busy        = (state_q != StIdle) | hold_full_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer (defaults except CNT_W = 4 so the
// frame counter wraps within a short run). Honors FRAME_SERIALIZER_PARITY_EN.
module tb_frame_serializer;

  localparam int unsigned DataW   = 16;
  localparam int unsigned BitDiv  = 4;
  localparam int unsigned CntW    = 4;
  localparam logic [7:0]  Sync    = 8'hA5;
`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int unsigned ParB    = 1;
`else
  localparam int unsigned ParB    = 0;
`endif
  localparam int unsigned FrameBits = 8 + DataW + ParB;
  localparam int unsigned FrameCyc  = FrameBits * BitDiv;
  localparam int          GapCyc    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [DataW-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             ser_dout;
  logic             ser_frame;
  logic             ser_bit_stb;
  logic             busy;
  logic [CntW-1:0]  frame_cnt;

  frame_serializer #(
    .CNT_W(CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .ser_dout   (ser_dout),
    .ser_frame  (ser_frame),
    .ser_bit_stb(ser_bit_stb),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DataW-1:0] data;
    logic             par;  // hand-computed even parity of data
    int               gap;  // expected idle cycles before this frame, -1 = don't care
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: rebuilds each frame from the serial line and pops the scoreboard.
  initial begin
    logic            prev_frame;
    int              flen, nbits, last_end;
    logic [63:0]     got, ev;
    logic            stb_bad, idle_bad;
    logic [CntW-1:0] model_cnt;
    exp_t            e;
    prev_frame = 1'b0; flen = 0; nbits = 0; last_end = -1; got = '0;
    stb_bad = 1'b0; idle_bad = 1'b0; model_cnt = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        prev_frame = 1'b0; flen = 0; nbits = 0; got = '0;
        stb_bad = 1'b0; idle_bad = 1'b0; model_cnt = '0;
      end else begin
        if (ser_frame && !prev_frame) begin
          check("idle_line_low", idle_bad, 0);
          idle_bad = 1'b0;
          check("frame_expected", q.size() > 0, 1);
          if (q.size() > 0 && q[0].gap >= 0) check("gap_cycles", cyc - last_end, q[0].gap);
          flen = 0; nbits = 0; got = '0; stb_bad = 1'b0;
        end
        if (ser_frame) begin
          if (ser_bit_stb !== ((flen % BitDiv) == 0)) stb_bad = 1'b1;
          if (ser_bit_stb) begin
            got = {got[62:0], ser_dout};
            nbits++;
          end
          flen++;
        end else if (ser_dout !== 1'b0) begin
          idle_bad = 1'b1;
        end
        if (!ser_frame && prev_frame) begin
          last_end  = cyc;
          model_cnt = model_cnt + 1'b1;
          check("frame_pending", q.size() > 0, 1);
          if (q.size() > 0) begin
            e  = q.pop_front();
            ev = {40'b0, Sync, e.data};
`ifdef FRAME_SERIALIZER_PARITY_EN
            ev = {ev[62:0], e.par};
`endif
            check("frame_bits", got, ev);
            check("frame_len", flen, FrameCyc);
            check("stb_count", nbits, FrameBits);
            check("stb_timing", stb_bad, 0);
            check("frame_cnt", frame_cnt, model_cnt);
          end
        end
        prev_frame = ser_frame;
      end
    end
  end

  // Call at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [DataW-1:0] d, input logic p, input int gap);
    int n;
    exp_t e;
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", s_ready, 1);
    e.data = d; e.par = p; e.gap = gap;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", busy, 0);
    @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
  endtask

  logic [DataW-1:0] tbl_d [4] = '{16'h0001, 16'h0003, 16'hC3A1, 16'hFFFF};
  logic             tbl_p [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic bad;
    int   fcount;
    reset = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {s_ready, ser_dout, ser_frame, ser_bit_stb, busy, frame_cnt}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", s_ready, 1);

    // 1: single word, first-bit latency
    send(16'hC3A1, 1'b1, -1);
    check("t1_wait_frame", ser_frame, 0);
    check("t1_ready_low", s_ready, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_load", {ser_frame, ser_dout, ser_bit_stb, s_ready}, 4'b1111);
    wait_drain();
    check("t1_cnt", frame_cnt, 1);

    // 2: back-to-back words
    send(16'h0001, 1'b1, -1);
    send(16'hFFFF, 1'b0, GapCyc);
    wait_drain();
    check("t2_cnt", frame_cnt, 3);

    // 3: word held while en is low
    en = 1'b0;
    send(16'h1234, 1'b1, -1);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if ({ser_frame, s_ready, busy} !== 3'b001) bad = 1'b1;
    end
    check("t3_en_low_hold", bad, 0);
    en = 1'b1;
    @(negedge clk);
    check("t3_en_rise_start", ser_frame, 1);
    wait_drain();
    check("t3_cnt", frame_cnt, 4);

    // 4: reset during data bit 5 with a second word held
    send(16'hC3A1, 1'b1, -1);
    send(16'h0003, 1'b0, GapCyc);
    repeat (52) @(negedge clk);
    check("t4_mid_frame", {ser_frame, busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("t4_abort_outputs", {s_ready, ser_dout, ser_frame, ser_bit_stb, busy, frame_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_ready_after", s_ready, 1);
    check("t4_not_busy", busy, 0);
    fcount = 0;
    repeat (150) begin
      @(negedge clk);
      if (ser_frame) fcount++;
    end
    check("t4_no_residual", fcount, 0);

    // 5/6: 17 back-to-back frames, counter wraps at 16, parity vectors
    for (int k = 0; k < 17; k++) begin
      send(tbl_d[k % 4], tbl_p[k % 4], (k == 0) ? -1 : GapCyc);
    end
    wait_drain();
    check("t5_cnt_wrapped", frame_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
